// File: rtl/fb_pkg.sv
// Shared framebuffer-fill types and default geometry for the VGA write path.
package fb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StFill  = 2'd2,
    StDone  = 2'd3
  } fb_state_e;

  localparam int unsigned FbHd        = 1280;
  localparam int unsigned FbVd        = 1024;
  localparam int unsigned FbXBits     = 11;
  localparam int unsigned FbYBits     = 11;
  localparam int unsigned FbColorBits = 2;

endpackage

// File: rtl/fb_raster_cnt.sv
// 2-D raster counter: load (xl, yt), step x to xr, then wrap to xl and step y to yb.
module fb_raster_cnt #(
  parameter int unsigned X_BITS = 11,
  parameter int unsigned Y_BITS = 11
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [X_BITS-1:0] xl_i,
  input  logic [Y_BITS-1:0] yt_i,
  input  logic [X_BITS-1:0] xr_i,
  input  logic [Y_BITS-1:0] yb_i,
  output logic [X_BITS-1:0] x_o,
  output logic [Y_BITS-1:0] y_o,
  output logic              last_o
);

  logic [X_BITS-1:0] r_x;
  logic [Y_BITS-1:0] r_y;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_x <= '0;
      r_y <= '0;
    end else if (load_i) begin
      r_x <= xl_i;
      r_y <= yt_i;
    end else if (en_i) begin
      if (r_x != xr_i) begin
        r_x <= r_x + 1'b1;
      end else if (r_y != yb_i) begin
        r_x <= xl_i;
        r_y <= r_y + 1'b1;
      end
    end
  end

  assign x_o    = r_x;
  assign y_o    = r_y;
  assign last_o = (r_x == xr_i) && (r_y == yb_i);

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill controller driving the framebuffer write port, one pixel per clock.
// Define FB_FILL_CLIP_EN to clamp out-of-range rectangles instead of rejecting them.
import fb_pkg::*;

module fb_rect_fill #(
  parameter int unsigned HD         = FbHd,
  parameter int unsigned VD         = FbVd,
  parameter int unsigned X_BITS     = FbXBits,
  parameter int unsigned Y_BITS     = FbYBits,
  parameter int unsigned COLOR_BITS = FbColorBits
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [X_BITS-1:0]     cmd_x0_i,
  input  logic [X_BITS-1:0]     cmd_x1_i,
  input  logic [Y_BITS-1:0]     cmd_y0_i,
  input  logic [Y_BITS-1:0]     cmd_y1_i,
  input  logic [COLOR_BITS-1:0] cmd_color_i,
  input  logic                  abort_i,
  output logic                  we_o,
  output logic [X_BITS-1:0]     addr_x_o,
  output logic [Y_BITS-1:0]     addr_y_o,
  output logic [COLOR_BITS-1:0] color_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  fb_state_e r_state, w_state_next;

  logic [X_BITS-1:0]     r_x0, r_x1;
  logic [Y_BITS-1:0]     r_y0, r_y1;
  logic [COLOR_BITS-1:0] r_color;

  logic [X_BITS-1:0] w_x_lo, w_x_hi, w_xl, w_xr;
  logic [Y_BITS-1:0] w_y_lo, w_y_hi, w_yt, w_yb;
  logic              w_reject, w_last, w_load, w_en;

  assign w_x_lo = (r_x0 < r_x1) ? r_x0 : r_x1;
  assign w_x_hi = (r_x0 < r_x1) ? r_x1 : r_x0;
  assign w_y_lo = (r_y0 < r_y1) ? r_y0 : r_y1;
  assign w_y_hi = (r_y0 < r_y1) ? r_y1 : r_y0;

`ifdef FB_FILL_CLIP_EN
  localparam logic [X_BITS-1:0] XMax = X_BITS'(HD - 1);
  localparam logic [Y_BITS-1:0] YMax = Y_BITS'(VD - 1);

  assign w_xl     = (w_x_lo > XMax) ? XMax : w_x_lo;
  assign w_xr     = (w_x_hi > XMax) ? XMax : w_x_hi;
  assign w_yt     = (w_y_lo > YMax) ? YMax : w_y_lo;
  assign w_yb     = (w_y_hi > YMax) ? YMax : w_y_hi;
  assign w_reject = 1'b0;
  assign err_o    = 1'b0;
`else
  logic r_err;

  assign w_xl     = w_x_lo;
  assign w_xr     = w_x_hi;
  assign w_yt     = w_y_lo;
  assign w_yb     = w_y_hi;
  assign w_reject = (32'(w_xr) >= HD) || (32'(w_yb) >= VD);

  // Pulses in the first IDLE cycle after a rejecting SETUP; abort wins over reject.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == StSetup) && !abort_i && w_reject;
    end
  end

  assign err_o = r_err;
`endif

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_x0    <= '0;
      r_x1    <= '0;
      r_y0    <= '0;
      r_y1    <= '0;
      r_color <= '0;
    end else if ((r_state == StIdle) && cmd_valid_i) begin
      r_x0    <= cmd_x0_i;
      r_x1    <= cmd_x1_i;
      r_y0    <= cmd_y0_i;
      r_y1    <= cmd_y1_i;
      r_color <= cmd_color_i;
    end
  end

  assign w_load = (r_state == StSetup);
  assign w_en   = (r_state == StFill) && !w_last;

  fb_raster_cnt #(
    .X_BITS(X_BITS),
    .Y_BITS(Y_BITS)
  ) u_raster_cnt (
    .clk_i  (clk_i),
    .arstn_i(arstn_i),
    .load_i (w_load),
    .en_i   (w_en),
    .xl_i   (w_xl),
    .yt_i   (w_yt),
    .xr_i   (w_xr),
    .yb_i   (w_yb),
    .x_o    (addr_x_o),
    .y_o    (addr_y_o),
    .last_o (w_last)
  );

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (cmd_valid_i) w_state_next = StSetup;
      StSetup: begin
        if (abort_i || w_reject) w_state_next = StIdle;
        else                     w_state_next = StFill;
      end
      StFill: begin
        if (abort_i)     w_state_next = StIdle;
        else if (w_last) w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready_o = 1'b0;
    we_o        = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    unique case (r_state)
      StIdle:  cmd_ready_o = 1'b1;
      StSetup: busy_o      = 1'b1;
      StFill: begin
        busy_o = 1'b1;
        we_o   = 1'b1;
      end
      StDone:  done_o      = 1'b1;
      default: cmd_ready_o = 1'b0;
    endcase
  end

  assign color_o = r_color;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill: directed and random rectangles against a raster model.
module tb_fb_rect_fill;

  localparam int HD = 1280;
  localparam int VD = 1024;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [10:0] cmd_x0_i, cmd_x1_i;
  logic [10:0] cmd_y0_i, cmd_y1_i;
  logic [1:0]  cmd_color_i;
  logic        abort_i;
  logic        we_o;
  logic [10:0] addr_x_o;
  logic [10:0] addr_y_o;
  logic [1:0]  color_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int n_chk  = 0;
  int n_fail = 0;

  fb_rect_fill u_dut (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_x0_i   (cmd_x0_i),
    .cmd_x1_i   (cmd_x1_i),
    .cmd_y0_i   (cmd_y0_i),
    .cmd_y1_i   (cmd_y1_i),
    .cmd_color_i(cmd_color_i),
    .abort_i    (abort_i),
    .we_o       (we_o),
    .addr_x_o   (addr_x_o),
    .addr_y_o   (addr_y_o),
    .color_o    (color_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: normalise corners, then clamp or reject against the visible area.
  task automatic model(input int x0, input int y0, input int x1, input int y1,
                       output int xl, output int xr, output int yt, output int yb,
                       output bit rej);
    xl  = (x0 < x1) ? x0 : x1;
    xr  = (x0 < x1) ? x1 : x0;
    yt  = (y0 < y1) ? y0 : y1;
    yb  = (y0 < y1) ? y1 : y0;
    rej = 1'b0;
`ifdef FB_FILL_CLIP_EN
    if (xl > HD - 1) xl = HD - 1;
    if (xr > HD - 1) xr = HD - 1;
    if (yt > VD - 1) yt = VD - 1;
    if (yb > VD - 1) yb = VD - 1;
`else
    rej = (xr >= HD) || (yb >= VD);
`endif
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready_o !== 1'b1 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("ready_timeout", 32'(cmd_ready_o), 32'd1);
  endtask

  task automatic drive(input int x0, input int y0, input int x1, input int y1, input int c);
    cmd_x0_i    = 11'(x0);
    cmd_y0_i    = 11'(y0);
    cmd_x1_i    = 11'(x1);
    cmd_y1_i    = 11'(y1);
    cmd_color_i = 2'(c);
  endtask

  // Issue a command and stop at the negedge of its SETUP cycle.
  task automatic send(input int x0, input int y0, input int x1, input int y1, input int c);
    wait_ready();
    drive(x0, y0, x1, y1, c);
    cmd_valid_i = 1'b1;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    chk("setup_busy", 32'(busy_o), 32'd1);
    chk("setup_we", 32'(we_o), 32'd0);
    chk("setup_ready", 32'(cmd_ready_o), 32'd0);
  endtask

  // From the SETUP negedge: check every write, then done (or abort/reject outcome).
  task automatic expect_fill(input int x0, input int y0, input int x1, input int y1,
                             input int c, input int abort_at);
    int xl, xr, yt, yb, k;
    bit rej;
    model(x0, y0, x1, y1, xl, xr, yt, yb, rej);
    if (rej) begin
      @(negedge clk_i);
      chk("rej_err", 32'(err_o), 32'd1);
      chk("rej_we", 32'(we_o), 32'd0);
      chk("rej_ready", 32'(cmd_ready_o), 32'd1);
      @(negedge clk_i);
      chk("rej_err_pulse", 32'(err_o), 32'd0);
      chk("rej_no_write", 32'(we_o), 32'd0);
      return;
    end
    k = 0;
    for (int y = yt; y <= yb; y++) begin
      for (int x = xl; x <= xr; x++) begin
        @(negedge clk_i);
        chk("fill_we", 32'(we_o), 32'd1);
        chk("fill_x", 32'(addr_x_o), 32'(x));
        chk("fill_y", 32'(addr_y_o), 32'(y));
        chk("fill_color", 32'(color_o), 32'(c));
        chk("fill_done", 32'(done_o), 32'd0);
        k++;
        if (k == abort_at) begin
          abort_i = 1'b1;
          @(negedge clk_i);
          abort_i = 1'b0;
          chk("abort_we", 32'(we_o), 32'd0);
          chk("abort_done", 32'(done_o), 32'd0);
          chk("abort_busy", 32'(busy_o), 32'd0);
          chk("abort_ready", 32'(cmd_ready_o), 32'd1);
          return;
        end
      end
    end
    @(negedge clk_i);
    chk("done_pulse", 32'(done_o), 32'd1);
    chk("done_we", 32'(we_o), 32'd0);
    chk("done_busy", 32'(busy_o), 32'd0);
    chk("done_ready", 32'(cmd_ready_o), 32'd0);
    chk("done_err", 32'(err_o), 32'd0);
    @(negedge clk_i);
    chk("post_done", 32'(done_o), 32'd0);
    chk("post_ready", 32'(cmd_ready_o), 32'd1);
  endtask

  task automatic do_cmd(input int x0, input int y0, input int x1, input int y1,
                        input int c, input int abort_at);
    send(x0, y0, x1, y1, c);
    expect_fill(x0, y0, x1, y1, c, abort_at);
  endtask

  initial begin
    arstn_i     = 1'b0;
    cmd_valid_i = 1'b0;
    abort_i     = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12;
    chk("rst_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_x", 32'(addr_x_o), 32'd0);
    chk("rst_y", 32'(addr_y_o), 32'd0);
    chk("rst_color", 32'(color_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    @(negedge clk_i);
    arstn_i = 1'b1;
    @(negedge clk_i);

    do_cmd(2, 3, 4, 4, 1, 0);
    do_cmd(10, 5, 8, 5, 3, 0);

    // Single pixel with valid held high: the second command waits for ready.
    wait_ready();
    drive(7, 7, 7, 7, 3);
    cmd_valid_i = 1'b1;
    @(negedge clk_i);
    chk("hold_setup_ready", 32'(cmd_ready_o), 32'd0);
    drive(1, 1, 2, 1, 2);
    expect_fill(7, 7, 7, 7, 3, 0);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    chk("hold_second_busy", 32'(busy_o), 32'd1);
    expect_fill(1, 1, 2, 1, 2, 0);

    do_cmd(0, 0, 3, 3, 2, 3);
    do_cmd(1276, 10, 1300, 10, 1, 0);

    // Asynchronous reset in the middle of a fill.
    send(0, 0, 3, 3, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("prerst_we", 32'(we_o), 32'd1);
      chk("prerst_x", 32'(addr_x_o), 32'(i));
    end
    #2;
    arstn_i = 1'b0;
    #1;
    chk("arst_we", 32'(we_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_x", 32'(addr_x_o), 32'd0);
    chk("arst_y", 32'(addr_y_o), 32'd0);
    chk("arst_color", 32'(color_o), 32'd0);
    chk("arst_done", 32'(done_o), 32'd0);
    chk("arst_ready", 32'(cmd_ready_o), 32'd1);
    @(negedge clk_i);
    arstn_i = 1'b1;
    @(negedge clk_i);
    do_cmd(5, 6, 6, 6, 2, 0);

    for (int i = 0; i < 12; i++) begin
      int x0, x1, y0, y1, c, ab;
      x0 = int'($urandom_range(0, 9));
      x1 = int'($urandom_range(0, 9));
      y0 = int'($urandom_range(0, 6));
      y1 = int'($urandom_range(0, 6));
      c  = int'($urandom_range(0, 3));
      ab = (i % 3 == 2) ? int'($urandom_range(1, 4)) : 0;
      if (i % 4 == 3) begin
        y0 = int'($urandom_range(1020, 1023));
        y1 = int'($urandom_range(1020, 1030));
      end
      do_cmd(x0, y0, x1, y1, c, ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
